// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with integrated busy-bit scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int REG_ZERO     = 0;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue sets, writeback clears, set wins on collision; bit 0 never busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = clog2(NUM_REGS_DEF)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_dst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (wr_en && (wr_addr != ADDR_W'(REG_ZERO))) begin
            busy_d[wr_addr] = 1'b0;
        end
        // Applied after the clear so a new producer supersedes the retiring one.
        if (iss_valid && (iss_dst != ADDR_W'(REG_ZERO))) begin
            busy_d[iss_dst] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file: N combinational read ports with write bypass, zero register,
// and a scoreboard exposing per-port RAW hazard flags.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int  DATA_W   = DATA_W_DEF,
    parameter int  NUM_REGS = NUM_REGS_DEF,
    parameter int  NUM_RD   = 2,
    localparam int ADDR_W   = clog2(NUM_REGS)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_dst,
    output logic [NUM_REGS-1:0]      busy_vec
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_act;

    assign wr_act = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

    always_comb begin
        regs_d = regs_q;
        if (wr_act) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clock     (clock),
        .reset_n   (reset_n),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy_vec  (busy)
    );

    assign busy_vec = busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] idx;
        logic              is_zero;
        logic              hit;

        assign idx     = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero = (idx == ADDR_W'(REG_ZERO));
        // Bypass is suppressed while reset is held so reads stay zero.
        assign hit     = wr_en && reset_n && (wr_addr == idx);

        assign rd_data[k*DATA_W +: DATA_W] = is_zero ? '0      :
                                             hit     ? wr_data :
                                                       regs_q[idx];
        assign rd_busy[k] = busy[idx] && !hit;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the CPU integer register file. It adds the following over the current block:
- N combinational read ports with same-cycle write-to-read bypass.
- Posedge writes and asynchronous clear.
- An integrated busy-bit scoreboard that tracks outstanding writebacks, so decode can detect RAW hazards.

It sits between decode (read/issue) and writeback (write/clear).

Parameters:
DATA_W, 32, width of each register in bits
NUM_REGS, 32, number of architectural registers; power of 2, >=2
NUM_RD, 2, number of independent read ports, >=1
ADDR_W, $clog2(NUM_REGS), register index width; derived, not overridden

Ports:
clock  in  1  system clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
rd_addr  in  NUM_RD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_busy  out  NUM_RD  per-port: source register has a pending write not yet satisfied
wr_en  in  1  writeback write enable
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_valid  in  1  instruction issued that will later write iss_dst
iss_dst  in  ADDR_W  destination of issued instruction
busy_vec  out  NUM_REGS  raw scoreboard bits, for debug and stall logic

Behaviour:
- Reset:
  - reset_n low asynchronously clears all registers to 0 and all busy bits to 0.
  - While reset is held: rd_data = 0, rd_busy = 0, busy_vec = 0.
  - The release edge performs no write.
- Register 0:
  - Hardwired zero; writes to index 0 are discarded.
  - Reads of index 0 return 0 on every port.
  - busy[0] is never set, so rd_busy for index 0 is always 0.
- Write:
  - On posedge clock with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - Write latency is 1 cycle to storage.
- Read, combinational for every port k:
  - Address 0 -> 0.
  - Else if wr_en && wr_addr==rd_addr[k] -> wr_data (bypass, so effective read latency is 0).
  - Else -> reg[rd_addr[k]].
  - Duplicate addresses across ports return identical data.
- Scoreboard, on posedge clock:
  - Set: iss_valid && iss_dst!=0 sets busy[iss_dst].
  - Clear: wr_en && wr_addr!=0 clears busy[wr_addr].
  - Same index set and cleared in one cycle: set wins. The new producer supersedes the retiring one, so the bit stays 1.
  - Set of an already-busy register: stays 1 (no counting; the pipeline guarantees in-order writeback per register).
  - Clear of a non-busy register: stays 0, with no error.
- rd_busy[k] = busy[rd_addr[k]] && !(wr_en && wr_addr==rd_addr[k]).
  - The clearing write is bypassed in the same cycle, so the consumer need not stall.
  - The iss_* inputs have no combinational effect on rd_busy in the current cycle. A same-cycle issue becomes visible in busy_vec and rd_busy on the next cycle.
- Reset mid-operation: pending busy bits and register contents are lost immediately. In-flight wr_en in that cycle is ignored.
- Widths: no arithmetic. Index compares are full ADDR_W. Data passes through unmodified.

Decomposition:
- regfile_pkg holds:
  - the function clog2 used for ADDR_W;
  - localparam REG_ZERO = 0;
  - default widths DATA_W_DEF=32, NUM_REGS_DEF=32.
- Sub-module regfile_scoreboard (NUM_REGS, ADDR_W):
  - inputs: clock, reset_n, iss_valid, iss_dst, wr_en, wr_addr;
  - output: busy_vec;
  - contains the set/clear priority logic.
- The top level holds the storage array, read muxes/bypass, and rd_busy generation.

Test Plan:
Defaults apply (DATA_W=32, NUM_REGS=32, NUM_RD=2).
1. Reset: pulse reset_n low mid-cycle after writing reg5=0xDEAD_BEEF -> immediately rd_data port0 (addr 5)=0 and busy_vec=0, without waiting for a clock edge.
2. Write/read and zero register:
   - wr_en=1, wr_addr=7, wr_data=0x1234_5678, one edge -> port0 addr7 reads 0x1234_5678 on later cycles.
   - Write 0xFFFF_FFFF to addr 0 -> port1 addr0 reads 0.
3. Bypass: reg3 holds 0x11; same cycle drive wr_en=1, wr_addr=3, wr_data=0x22 with rd_addr port0=3, port1=3 -> both ports read 0x22 combinationally before the edge, and 0x22 after it.
4. Scoreboard lifecycle:
   - iss_valid=1, iss_dst=9 at edge N -> busy_vec[9]=1 and rd_busy for addr9=1 from cycle N+1.
   - wr_en to 9 in cycle M -> rd_busy=0 already in cycle M (bypass), busy_vec[9]=0 after edge M.
5. Set/clear collision: busy[4]=1; in one cycle drive iss_valid with iss_dst=4 and wr_en with wr_addr=4, wr_data=0xAA -> after the edge busy_vec[4]=1, reg4=0xAA.
6. Parameter sweep: NUM_REGS=8, NUM_RD=3, DATA_W=16 -> repeat scenarios 2–4 on three ports with addr 0..7. Addr-0 rules and bypass must hold on all ports.
